znz_decoder_arbiter: RTL

- Shares one znz_decoder datapath between N_CH independent requesters. Each requester supplies one ZNZ mask beat and one encoded-data beat per job.
- Round-robin arbitration; the grant is locked for the whole job.
- Both beats of the winning channel are steered into the decoder.
- Decoded results return in order and are demuxed to the originating channel using an in-order channel-tag FIFO.
- Sits between the per-channel request streams and the existing decoder wrapper.

---
 rtl/znz_pkg.sv | 43 ++++
 rtl/generic_sync_fifo.sv | 63 ++++++
 rtl/znz_decoder_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/znz_pkg.sv
`default_nettype none
// ============================================================================
// Module   : znz_pkg
// Purpose  : Shared types and round-robin helper for the ZNZ decoder arbiter.
// Revision : 1.0
// ============================================================================
package znz_pkg;

    localparam int C_N_CH      = 4;
    localparam int C_ZNZ_BITS  = 128;
    localparam int C_DATA_W    = 8;
    localparam int C_TAG_DEPTH = 4;

    typedef logic [$clog2(C_N_CH)-1:0] ch_id_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic   found;
        ch_id_t idx;
    } rr_pick_t;

    // First set bit of eligible at or after ptr, wrapping modulo C_N_CH.
    function automatic rr_pick_t rr_pick(input logic [C_N_CH-1:0] eligible,
                                         input ch_id_t            ptr);
        rr_pick_t res;
        res = '0;
        for (int i = 0; i < C_N_CH; i++) begin
            int j;
            j = (int'(ptr) + i) % C_N_CH;
            if (!res.found && eligible[j]) begin
                res.found = 1'b1;
                res.idx   = ch_id_t'(j);
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/generic_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : generic_sync_fifo
// Purpose  : Single-clock FIFO of arbitrary element type; pop frees a slot
//            for a push in the same cycle even when full.
// Revision : 1.0
// ============================================================================
module generic_sync_fifo #(
    parameter type DTYPE      = logic [7:0],
    parameter int  FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  DTYPE din,
    input  logic pop,
    output DTYPE dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    DTYPE             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/znz_decoder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : znz_decoder_arbiter
// Purpose  : Round-robin sharing of one ZNZ decoder among N_CH requesters,
//            with in-order result routing through a channel-tag FIFO.
// Revision : 1.0
// ============================================================================
module znz_decoder_arbiter
    import znz_pkg::*;
#(
    parameter int N_CH      = C_N_CH,
    parameter int ZNZ_BITS  = C_ZNZ_BITS,
    parameter int DATA_W    = C_DATA_W,
    parameter int TAG_DEPTH = C_TAG_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_CH*ZNZ_BITS-1:0]          req_znz_din,
    input  logic [N_CH-1:0]                   req_znz_vld,
    output logic [N_CH-1:0]                   req_znz_rdy,
    input  logic [N_CH*ZNZ_BITS*DATA_W-1:0]   req_enc_din,
    input  logic [N_CH-1:0]                   req_enc_vld,
    output logic [N_CH-1:0]                   req_enc_rdy,
    output logic [ZNZ_BITS*DATA_W-1:0]        ch_dec_dout,
    output logic [N_CH-1:0]                   ch_dec_vld,
    input  logic [N_CH-1:0]                   ch_dec_rdy,
    output logic [ZNZ_BITS-1:0]               dec_znz_din,
    output logic                              dec_znz_vld,
    input  logic                              dec_znz_rdy,
    output logic [ZNZ_BITS*DATA_W-1:0]        dec_enc_din,
    output logic                              dec_enc_vld,
    input  logic                              dec_enc_rdy,
    input  logic [ZNZ_BITS*DATA_W-1:0]        dec_dout,
    input  logic                              dec_vld,
    output logic                              dec_rdy,
    output logic                              busy,
    output logic [$clog2(N_CH)-1:0]           grant_id,
    output logic                              err
);

    localparam int ENC_W = ZNZ_BITS * DATA_W;

    arb_state_e      state;
    arb_state_e      state_nxt;
    ch_id_t          gnt_ch;
    ch_id_t          rr_ptr;
    logic            znz_done;
    logic            enc_done;
    logic [N_CH-1:0] eligible;
    rr_pick_t        pick;
    logic            arb_go;
    logic            znz_hs;
    logic            enc_hs;
    logic            job_done;
    logic            tag_full;
    logic            tag_empty;
    logic            tag_pop;
    ch_id_t          tag_head;

    assign eligible = req_znz_vld & req_enc_vld;
    assign pick     = rr_pick(eligible, rr_ptr);
    // Arbitrating only when not full reserves the FIFO slot for the whole job.
    assign arb_go   = (state == IDLE) & pick.found & ~tag_full;
    assign znz_hs   = dec_znz_vld & dec_znz_rdy;
    assign enc_hs   = dec_enc_vld & dec_enc_rdy;
    assign job_done = (state == GRANT) & (znz_done | znz_hs) & (enc_done | enc_hs);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_go)   state_nxt = GRANT;
            GRANT:   if (job_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_ch   <= '0;
            rr_ptr   <= '0;
            znz_done <= 1'b0;
            enc_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (arb_go) gnt_ch <= pick.idx;
            if (job_done) begin
                znz_done <= 1'b0;
                enc_done <= 1'b0;
                rr_ptr   <= (gnt_ch == ch_id_t'(N_CH - 1)) ? '0 : gnt_ch + 1'b1;
            end else begin
                if (znz_hs) znz_done <= 1'b1;
                if (enc_hs) enc_done <= 1'b1;
            end
            if (dec_vld && tag_empty) err <= 1'b1;
        end
    end

    assign dec_znz_din = req_znz_din[int'(gnt_ch)*ZNZ_BITS +: ZNZ_BITS];
    assign dec_enc_din = req_enc_din[int'(gnt_ch)*ENC_W +: ENC_W];

    always_comb begin
        req_znz_rdy = '0;
        req_enc_rdy = '0;
        dec_znz_vld = 1'b0;
        dec_enc_vld = 1'b0;
        if (state == GRANT) begin
            dec_znz_vld         = req_znz_vld[gnt_ch] & ~znz_done;
            dec_enc_vld         = req_enc_vld[gnt_ch] & ~enc_done;
            req_znz_rdy[gnt_ch] = dec_znz_rdy & ~znz_done;
            req_enc_rdy[gnt_ch] = dec_enc_rdy & ~enc_done;
        end
    end

    always_comb begin
        ch_dec_vld           = '0;
        ch_dec_vld[tag_head] = dec_vld & ~tag_empty;
    end

    assign dec_rdy     = ~tag_empty & ch_dec_rdy[tag_head];
    assign tag_pop     = dec_vld & dec_rdy;
    assign ch_dec_dout = dec_dout;
    assign busy        = (state == GRANT);
    assign grant_id    = gnt_ch;

    generic_sync_fifo #(
        .DTYPE      (ch_id_t),
        .FIFO_DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (znz_hs),
        .din   (gnt_ch),
        .pop   (tag_pop),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

endmodule
`default_nettype wire
